// File: rtl/counter_monitor.sv
// counter_monitor: passive checker for a packed {overflow, count} counter bus.
// Rebuilds the expected count from the sampled enable, flags mismatches,
// counts MAX->0 wraps and reports lock/fault status.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SYNC     | waiting for a clean zero sample (cnt==0, ovf==0); no checks
// TRACK    | comparing every sample against the rebuilt model
// FAULT    | sticky mismatch seen; checks and statistics frozen until rst
module counter_monitor #(
    parameter int W      = 8,
    parameter int CNT_W  = 16,
    parameter int STICKY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [W:0]       output_packed,
    output logic             locked,
    output logic             fault,
    output logic             error,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [W:0]       last_bad
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [W-1:0]     CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0]     CNT_ZERO = {W{1'b0}};
    localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     prev_count_q;
    logic             prev_en_q;
    logic             error_q, error_d;
    logic [CNT_W-1:0] error_count_q, error_count_d;
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
    logic [W:0]       last_bad_q, last_bad_d;

    logic [W-1:0]     cnt_s;
    logic             ovf_s;
    logic [W-1:0]     exp_cnt;
    logic             mismatch;
    logic             sync_hit;
    logic             wrap_hit;

    // Decode the sampled word and evaluate the model against it.
    // Case-inequality makes X/Z on the bus count as a mismatch while tracking.
    always_comb begin
        cnt_s    = output_packed[W-1:0];
        ovf_s    = output_packed[W];
        exp_cnt  = prev_count_q + {{(W-1){1'b0}}, prev_en_q};
        mismatch = (cnt_s !== exp_cnt) || (ovf_s !== (cnt_s == CNT_MAX));
        sync_hit = (cnt_s == CNT_ZERO) && (ovf_s == 1'b0);
        wrap_hit = (prev_count_q == CNT_MAX) && prev_en_q && (cnt_s == CNT_ZERO);
    end

    // Next-state, error pulse and statistics; FAULT freezes everything.
    always_comb begin
        state_d       = state_q;
        error_d       = 1'b0;
        error_count_d = error_count_q;
        wrap_count_d  = wrap_count_q;
        last_bad_d    = last_bad_q;
        case (state_q)
            ST_SYNC: begin
                if (sync_hit) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (mismatch) begin
                    error_d    = 1'b1;
                    last_bad_d = output_packed;
                    if (error_count_q != STAT_MAX) begin
                        error_count_d = error_count_q + STAT_ONE;
                    end
                    if (STICKY != 0) begin
                        state_d = ST_FAULT;
                    end
                end
                // A wrap still counts when the same sample has a bad ovf bit.
                if (wrap_hit && (wrap_count_q != STAT_MAX)) begin
                    wrap_count_d = wrap_count_q + STAT_ONE;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // State and statistic registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            error_q       <= 1'b0;
            error_count_q <= '0;
            wrap_count_q  <= '0;
            last_bad_q    <= '0;
        end else begin
            state_q       <= state_d;
            error_q       <= error_d;
            error_count_q <= error_count_d;
            wrap_count_q  <= wrap_count_d;
            last_bad_q    <= last_bad_d;
        end
    end

    // Previous sample is captured every edge in every state so the model is
    // primed by the time SYNC hands over to TRACK; it also resynchronises
    // the non-sticky model to the observed value after a mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_count_q <= '0;
            prev_en_q    <= 1'b0;
        end else begin
            prev_count_q <= cnt_s;
            prev_en_q    <= enable;
        end
    end

    assign locked      = (state_q == ST_TRACK);
    assign fault       = (state_q == ST_FAULT);
    assign error       = error_q;
    assign error_count = error_count_q;
    assign wrap_count  = wrap_count_q;
    assign last_bad    = last_bad_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a sticky, a non-sticky and a
// narrow-statistics non-sticky instance watch the same bench-driven counter.
`timescale 1ns/1ps
module tb_counter_monitor;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [8:0] pk;

    logic lk_s, ft_s, er_s;  logic [15:0] ec_s, wc_s;  logic [8:0] lb_s;
    logic lk_n, ft_n, er_n;  logic [15:0] ec_n, wc_n;  logic [8:0] lb_n;
    logic lk_t, ft_t, er_t;  logic [1:0]  ec_t, wc_t;  logic [8:0] lb_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] cnt_m;
    int err_pulse_s, err_pulse_n, err_pulse_t;

    counter_monitor #(.W(8), .CNT_W(16), .STICKY(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .output_packed(pk),
        .locked(lk_s), .fault(ft_s), .error(er_s),
        .error_count(ec_s), .wrap_count(wc_s), .last_bad(lb_s));

    counter_monitor #(.W(8), .CNT_W(16), .STICKY(0)) u_dut_ns (
        .clk(clk), .rst(rst), .enable(enable), .output_packed(pk),
        .locked(lk_n), .fault(ft_n), .error(er_n),
        .error_count(ec_n), .wrap_count(wc_n), .last_bad(lb_n));

    counter_monitor #(.W(8), .CNT_W(2), .STICKY(0)) u_dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .output_packed(pk),
        .locked(lk_t), .fault(ft_t), .error(er_t),
        .error_count(ec_t), .wrap_count(wc_t), .last_bad(lb_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_model();
        pk = {(cnt_m == 8'hFF), cnt_m};
    endtask

    // One clock: the bench counter advances on edges where enable was 1.
    task automatic tick();
        logic en_s;
        en_s = enable;
        @(posedge clk);
        #1;
        if (en_s && !rst) cnt_m = cnt_m + 8'd1;
        drive_model();
        if (er_s === 1'b1) err_pulse_s++;
        if (er_n === 1'b1) err_pulse_n++;
        if (er_t === 1'b1) err_pulse_t++;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        enable = 1'b0;
        cnt_m = 8'd0;
        drive_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        err_pulse_s = 0; err_pulse_n = 0; err_pulse_t = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; cnt_m = 8'd0; drive_model();
        #50;
        n_checks++; if (lk_s !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b want 0", lk_s); end
        n_checks++; if (ft_s !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %b want 0", ft_s); end
        n_checks++; if (er_s !== 1'b0) begin n_fail++; $display("FAIL rst_error got %b want 0", er_s); end
        n_checks++; if (ec_s !== 16'd0) begin n_fail++; $display("FAIL rst_error_count got %0d want 0", ec_s); end
        n_checks++; if (wc_s !== 16'd0) begin n_fail++; $display("FAIL rst_wrap_count got %0d want 0", wc_s); end
        n_checks++; if (lb_s !== 9'd0) begin n_fail++; $display("FAIL rst_last_bad got %h want 000", lb_s); end
        #50;
        rst = 1'b0;
        err_pulse_s = 0; err_pulse_n = 0; err_pulse_t = 0;
        tick();
        tick();
        n_checks++; if (lk_s !== 1'b1) begin n_fail++; $display("FAIL lock_after_rst got %b want 1", lk_s); end
        n_checks++; if (ec_s !== 16'd0) begin n_fail++; $display("FAIL lock_error_count got %0d want 0", ec_s); end
    endtask

    task automatic test_normal_run();
        enable = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 256) begin
                n_checks++; if (wc_s !== 16'd0) begin n_fail++; $display("FAIL wrap_early got %0d want 0", wc_s); end
            end
            if (i == 257) begin
                n_checks++; if (wc_s !== 16'd1) begin n_fail++; $display("FAIL wrap_edge got %0d want 1", wc_s); end
            end
        end
        n_checks++; if (wc_s !== 16'd1) begin n_fail++; $display("FAIL run_wrap_count got %0d want 1", wc_s); end
        n_checks++; if (wc_n !== 16'd1) begin n_fail++; $display("FAIL run_wrap_count_ns got %0d want 1", wc_n); end
        n_checks++; if (ec_s !== 16'd0) begin n_fail++; $display("FAIL run_error_count got %0d want 0", ec_s); end
        n_checks++; if (err_pulse_s !== 0) begin n_fail++; $display("FAIL run_error_pulses got %0d want 0", err_pulse_s); end
        n_checks++; if (lk_s !== 1'b1) begin n_fail++; $display("FAIL run_locked got %b want 1", lk_s); end
    endtask

    task automatic test_enable_gaps();
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            enable = pat[r];
            repeat (50) tick();
            n_checks++; if (lk_s !== 1'b1) begin n_fail++; $display("FAIL gap_locked run %0d got %b want 1", r, lk_s); end
        end
        n_checks++; if (err_pulse_s !== 0) begin n_fail++; $display("FAIL gap_error_pulses got %0d want 0", err_pulse_s); end
        n_checks++; if (ec_s !== 16'd0) begin n_fail++; $display("FAIL gap_error_count got %0d want 0", ec_s); end
        n_checks++; if (wc_s !== 16'd1) begin n_fail++; $display("FAIL gap_wrap_count got %0d want 1", wc_s); end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 40; i++) begin
            enable = ~enable;
            tick();
        end
        n_checks++; if (err_pulse_s !== 0) begin n_fail++; $display("FAIL toggle_error_pulses got %0d want 0", err_pulse_s); end
        n_checks++; if (lk_s !== 1'b1) begin n_fail++; $display("FAIL toggle_locked got %b want 1", lk_s); end
        n_checks++; if (ec_n !== 16'd0) begin n_fail++; $display("FAIL toggle_error_count_ns got %0d want 0", ec_n); end
    endtask

    task automatic test_fault_sticky();
        reset_all();
        enable = 1'b1;
        repeat (16) tick();
        tick();
        pk = 9'h012;
        tick();
        n_checks++; if (er_s !== 1'b1) begin n_fail++; $display("FAIL sticky_error got %b want 1", er_s); end
        n_checks++; if (ec_s !== 16'd1) begin n_fail++; $display("FAIL sticky_error_count got %0d want 1", ec_s); end
        n_checks++; if (lb_s !== 9'h012) begin n_fail++; $display("FAIL sticky_last_bad got %h want 012", lb_s); end
        n_checks++; if (ft_s !== 1'b1) begin n_fail++; $display("FAIL sticky_fault got %b want 1", ft_s); end
        n_checks++; if (lk_s !== 1'b0) begin n_fail++; $display("FAIL sticky_locked got %b want 0", lk_s); end
        tick();
        n_checks++; if (er_s !== 1'b0) begin n_fail++; $display("FAIL sticky_pulse_width got %b want 0", er_s); end
        repeat (5) tick();
        pk = 9'h1FF;
        tick();
        repeat (3) tick();
        n_checks++; if (err_pulse_s !== 1) begin n_fail++; $display("FAIL sticky_pulses got %0d want 1", err_pulse_s); end
        n_checks++; if (ec_s !== 16'd1) begin n_fail++; $display("FAIL sticky_frozen_count got %0d want 1", ec_s); end
        n_checks++; if (lb_s !== 9'h012) begin n_fail++; $display("FAIL sticky_frozen_last_bad got %h want 012", lb_s); end
        n_checks++; if (ft_s !== 1'b1) begin n_fail++; $display("FAIL sticky_fault_held got %b want 1", ft_s); end
    endtask

    task automatic test_fault_nonsticky();
        reset_all();
        enable = 1'b1;
        repeat (31) tick();
        tick();
        pk = 9'h120;
        tick();
        n_checks++; if (er_n !== 1'b1) begin n_fail++; $display("FAIL ns_error got %b want 1", er_n); end
        n_checks++; if (ec_n !== 16'd1) begin n_fail++; $display("FAIL ns_error_count got %0d want 1", ec_n); end
        n_checks++; if (lb_n !== 9'h120) begin n_fail++; $display("FAIL ns_last_bad got %h want 120", lb_n); end
        n_checks++; if (lk_n !== 1'b1) begin n_fail++; $display("FAIL ns_locked got %b want 1", lk_n); end
        n_checks++; if (ft_n !== 1'b0) begin n_fail++; $display("FAIL ns_fault got %b want 0", ft_n); end
        repeat (20) tick();
        n_checks++; if (err_pulse_n !== 1) begin n_fail++; $display("FAIL ns_pulses got %0d want 1", err_pulse_n); end
        n_checks++; if (ec_n !== 16'd1) begin n_fail++; $display("FAIL ns_error_count_after got %0d want 1", ec_n); end
        n_checks++; if (ft_s !== 1'b1) begin n_fail++; $display("FAIL ns_sticky_peer_fault got %b want 1", ft_s); end
    endtask

    task automatic test_midrun_reset();
        int guard;
        enable = 1'b1;
        repeat (256) tick();
        n_checks++; if (wc_n !== 16'd1) begin n_fail++; $display("FAIL mid_pre_wrap got %0d want 1", wc_n); end
        guard = 0;
        while (cnt_m != 8'h80 && guard < 300) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        #1;
        n_checks++; if (lk_n !== 1'b0) begin n_fail++; $display("FAIL mid_locked got %b want 0", lk_n); end
        n_checks++; if (ec_n !== 16'd0) begin n_fail++; $display("FAIL mid_error_count got %0d want 0", ec_n); end
        n_checks++; if (wc_n !== 16'd0) begin n_fail++; $display("FAIL mid_wrap_count got %0d want 0", wc_n); end
        n_checks++; if (lb_n !== 9'd0) begin n_fail++; $display("FAIL mid_last_bad got %h want 000", lb_n); end
        n_checks++; if (er_n !== 1'b0) begin n_fail++; $display("FAIL mid_error got %b want 0", er_n); end
        n_checks++; if (ft_s !== 1'b0) begin n_fail++; $display("FAIL mid_fault got %b want 0", ft_s); end
        cnt_m = 8'd0;
        enable = 1'b0;
        drive_model();
        #29;
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (lk_n !== 1'b1) begin n_fail++; $display("FAIL mid_relock_ns got %b want 1", lk_n); end
        n_checks++; if (lk_s !== 1'b1) begin n_fail++; $display("FAIL mid_relock got %b want 1", lk_s); end
        err_pulse_s = 0; err_pulse_n = 0;
        enable = 1'b1;
        repeat (300) tick();
        n_checks++; if (wc_n !== 16'd1) begin n_fail++; $display("FAIL mid_wrap_after got %0d want 1", wc_n); end
        n_checks++; if (wc_s !== 16'd1) begin n_fail++; $display("FAIL mid_wrap_after_s got %0d want 1", wc_s); end
        n_checks++; if (err_pulse_n !== 0) begin n_fail++; $display("FAIL mid_pulses got %0d want 0", err_pulse_n); end
    endtask

    task automatic test_saturation();
        reset_all();
        enable = 1'b1;
        repeat (4) tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            pk = {1'b1, cnt_m};
            tick();
            if (k == 1) begin
                n_checks++; if (ec_t !== 2'd1) begin n_fail++; $display("FAIL sat_first got %0d want 1", ec_t); end
            end
            tick();
        end
        n_checks++; if (ec_t !== 2'd3) begin n_fail++; $display("FAIL sat_error_count got %0d want 3", ec_t); end
        n_checks++; if (err_pulse_t !== 5) begin n_fail++; $display("FAIL sat_pulses got %0d want 5", err_pulse_t); end
        n_checks++; if (ec_n !== 16'd5) begin n_fail++; $display("FAIL sat_wide_count got %0d want 5", ec_n); end
        n_checks++; if (lk_t !== 1'b1) begin n_fail++; $display("FAIL sat_locked got %b want 1", lk_t); end
    endtask

    initial begin
        err_pulse_s = 0; err_pulse_n = 0; err_pulse_t = 0;
        test_reset();
        test_normal_run();
        test_enable_gaps();
        test_toggle();
        test_fault_sticky();
        test_fault_nonsticky();
        test_midrun_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
